aes192_key_schedule_seq: RTL and testbench
==========================================

Name: aes192_key_schedule_seq

Overview:
- Iterative AES-192 key-schedule sequencer for the AES-CTR datapath.
- Accepts one 192-bit cipher key through a valid/ready handshake.
- Expands it word-serially (FIPS-197 §5.2, Nk=6) and streams round keys RK0..RK12, 128 bits each, in order through a valid/ready output.
- Downstream consumer is the round-key store or pipelined round stages.
- Replaces the unrolled key-expansion chain where area matters more than latency.

Parameters:
- NUM_ROUND_KEYS, 13, number of round keys emitted (legal 1..13); the last one emitted asserts out_last.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  192  cipher key, word0 in [191:160].
- key_valid  input  1  key_in valid.
- key_ready  output  1  high only in IDLE; key accepted when key_valid&&key_ready.
- out_key  output  128  round key, word 4i in [127:96].
- out_index  output  4  round-key index i of out_key.
- out_valid  output  1  out_key/out_index/out_last valid.
- out_ready  input  1  consumer accepts when out_valid&&out_ready.
- out_last  output  1  high with the final round key (index NUM_ROUND_KEYS-1).
- busy  output  1  high whenever not IDLE.

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, key_ready=1, out_valid=0, out_last=0, busy=0, out_key=0, out_index=0, rcon=8'h01, word counter=0. rst mid-expansion aborts immediately; partial output discarded.
- Single clock; S-box via the codebase's S4 (four S-boxes, 1-cycle registered latency).
- States:
  - IDLE: key_ready=1. On accept, load 6-word window w0..w5 from key_in; go to EMIT.
  - EMIT: generate words, pack groups of 4, present round keys.
  - DRAIN: all words generated; wait for final handshake; then IDLE.
- Word generation, for i>=6:
  - w[i] = w[i-6] ^ temp.
  - temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0} when i%6==0; otherwise temp = w[i-1].
  - No SubWord-only step (Nk=6).
- Rate: one word per cycle when not stalled. i%6==0 words take 2 cycles (S4 latency), with one bubble.
- rcon: applied then updated to xtime(rcon) after each i%6==0 word; sequence 01,02,04,08,10,20,40,80.
- Packing: a 4-word assembly register feeds a single output register.
  - Cycle after load: out_valid=1, out_key={w0..w3}, out_index=0; w4,w5 preloaded in assembly (count 2).
  - When assembly reaches 4 words, it transfers to the output register only if that register is empty or handshaking in the same cycle.
  - Otherwise the generator stalls with no word loss; the S4 result is held in a register across the stall.
- Output held stable while out_valid&&!out_ready; out_valid only drops on handshake.
- Words beyond index 4*NUM_ROUND_KEYS-1 are not generated; w50/w51 are the last needed for 13 keys.
- After the handshake of out_last, go to IDLE; key_ready=1 on the next cycle. key_valid in the same cycle as the last handshake is ignored.
- key_valid while busy is ignored (key_ready=0); key_in is not sampled.
- NUM_ROUND_KEYS=1: emit RK0 with out_last=1, no generation.
- With out_ready held high, RK12 is presented 54±2 cycles after key accept. The bench checks an upper bound of 60 cycles and no gaps other than the i%6==0 bubbles.

Test Plan:
- FIPS-197 A.2 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, out_ready=1:
  - RK0 = 8e73b0f7da0e6452c810f32b809079e5, index 0.
  - RK1 = 62f8ead2522c6b7bfe0c91f72402f5a5.
  - RK2 begins ec12068e6c827f6b.
  - RK12 = e98ba06f448c773c8ecc720401002202 with out_last=1, index 12, within 60 cycles.
- Same key, out_ready randomly toggled (~30% low):
  - Identical 13-key sequence.
  - out_key/out_index stable while stalled.
  - No duplicated or skipped index.
- Reset pulse at cycle 20 of an expansion, then new all-zero key:
  - out_valid=0 the cycle after rst.
  - RK0 = 0.
  - RK1 = 0000000000000000 62636363 62636363.
  - Completes cleanly.
- key_valid held high throughout:
  - Second key accepted only the cycle after RK12 handshake.
  - key_ready=0 for the entire expansion.
- Hold out_ready=0 with RK0 pending for 100 cycles:
  - Generator stalls with at most one packed round key buffered.
  - Release yields correct RK1 and RK2.
- Build with NUM_ROUND_KEYS=1 and NUM_ROUND_KEYS=4:
  - out_last on index 0 and index 3 respectively.
  - Then IDLE.

Source files
------------

// File: rtl/aes192_key_schedule_seq_if.sv
// Key-load channel and round-key output channel of the AES-192 key-schedule sequencer.
interface aes192_key_schedule_seq_if;
  localparam int unsigned KEY_W   = 192;
  localparam int unsigned RK_W    = 128;
  localparam int unsigned INDEX_W = 4;

  logic [KEY_W-1:0]   key_in;
  logic               key_valid;
  logic               key_ready;
  logic [RK_W-1:0]    out_key;
  logic [INDEX_W-1:0] out_index;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;

  modport master (
    output key_in, key_valid, out_ready,
    input  key_ready, out_key, out_index, out_valid, out_last, busy
  );

  modport slave (
    input  key_in, key_valid, out_ready,
    output key_ready, out_key, out_index, out_valid, out_last, busy
  );
endinterface

// File: rtl/aes192_key_schedule_seq.sv
// Word-serial AES-192 key expansion (Nk=6) streaming 128-bit round keys over valid/ready.
module aes192_key_schedule_seq #(
  parameter int unsigned NUM_ROUND_KEYS = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  aes192_key_schedule_seq_if.slave bus
);
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned KEY_CNT_W = 5;
  localparam logic [IDX_W-1:0]     TOTAL_WORDS = IDX_W'(4 * NUM_ROUND_KEYS);
  localparam logic [KEY_CNT_W-1:0] LAST_KEY    = KEY_CNT_W'(NUM_ROUND_KEYS - 1);

  typedef enum logic [1:0] {IDLE, EMIT, DRAIN} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = xtime(s);
    end
    return p;
  endfunction

  // Inverse as x^254 (maps 0 to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
    r = gf_mul(r, r);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [WORD_W-1:0] sub_rot_word(input logic [WORD_W-1:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  state_e               state;
  state_e               state_nxt;
  logic                 key_ready_q;
  logic                 busy_q;
  logic                 key_ready_d;
  logic                 busy_d;

  logic [191:0]         win;
  logic [IDX_W-1:0]     idx;
  logic [2:0]           phase;
  logic [7:0]           rcon;
  logic [WORD_W-1:0]    sub_q;
  logic                 sub_valid;
  logic [127:0]         asm_q;
  logic [2:0]           asm_cnt;
  logic [2:0]           asm_cnt_nxt;
  logic [1:0]           asm_slot;
  logic [KEY_CNT_W-1:0] key_cnt;

  logic [127:0]         out_key_q;
  logic [3:0]           out_index_q;
  logic                 out_valid_q;
  logic                 out_last_q;

  logic                 accept;
  logic                 hs;
  logic                 xfer;
  logic                 more;
  logic                 sub_start;
  logic                 produce;
  logic [WORD_W-1:0]    temp;
  logic [WORD_W-1:0]    new_word;

  assign accept    = (state == IDLE) && bus.key_valid;
  assign hs        = out_valid_q && bus.out_ready;
  assign xfer      = (state == EMIT) && (asm_cnt == 3'd4) && (!out_valid_q || hs);
  assign more      = (state == EMIT) && (idx < TOTAL_WORDS);
  assign sub_start = more && (phase == 3'd0) && !sub_valid;
  // A word may enter the assembly in the same cycle the full assembly moves out.
  assign produce   = more && ((phase != 3'd0) || sub_valid) && ((asm_cnt != 3'd4) || xfer);
  assign temp      = (phase == 3'd0) ? (sub_q ^ {rcon, 24'h000000}) : win[31:0];
  assign new_word  = win[191:160] ^ temp;
  assign asm_slot  = xfer ? 2'd0 : asm_cnt[1:0];

  always_comb begin
    asm_cnt_nxt = asm_cnt;
    if (xfer)         asm_cnt_nxt = produce ? 3'd1 : 3'd0;
    else if (produce) asm_cnt_nxt = asm_cnt + 3'd1;
  end

  // State register, with key_ready/busy registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (NUM_ROUND_KEYS == 1) ? DRAIN : EMIT;
      EMIT:    if (xfer && (key_cnt == LAST_KEY)) state_nxt = DRAIN;
      DRAIN:   if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    key_ready_d = 1'b0;
    busy_d      = 1'b1;
    if (state_nxt == IDLE) begin
      key_ready_d = 1'b1;
      busy_d      = 1'b0;
    end
  end

  // Word generator, 4-word assembly and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      win         <= '0;
      idx         <= '0;
      phase       <= '0;
      rcon        <= 8'h01;
      sub_q       <= '0;
      sub_valid   <= 1'b0;
      asm_q       <= '0;
      asm_cnt     <= '0;
      key_cnt     <= '0;
      out_key_q   <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      win         <= bus.key_in;
      idx         <= IDX_W'(6);
      phase       <= '0;
      rcon        <= 8'h01;
      sub_valid   <= 1'b0;
      asm_q       <= {bus.key_in[63:0], 64'h0};
      asm_cnt     <= 3'd2;
      key_cnt     <= KEY_CNT_W'(1);
      out_key_q   <= bus.key_in[191:64];
      out_index_q <= '0;
      out_valid_q <= 1'b1;
      out_last_q  <= (NUM_ROUND_KEYS == 1);
    end else begin
      // S-box stage result is held until its word can be written.
      if (sub_start) begin
        sub_q     <= sub_rot_word(win[31:0]);
        sub_valid <= 1'b1;
      end
      if (produce) begin
        win   <= {win[159:0], new_word};
        idx   <= idx + IDX_W'(1);
        phase <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
        if (phase == 3'd0) begin
          rcon      <= xtime(rcon);
          sub_valid <= 1'b0;
        end
        unique case (asm_slot)
          2'd0:    asm_q[127:96] <= new_word;
          2'd1:    asm_q[95:64]  <= new_word;
          2'd2:    asm_q[63:32]  <= new_word;
          default: asm_q[31:0]   <= new_word;
        endcase
      end
      asm_cnt <= asm_cnt_nxt;
      if (xfer) begin
        out_key_q   <= asm_q;
        out_index_q <= key_cnt[3:0];
        out_last_q  <= (key_cnt == LAST_KEY);
        out_valid_q <= 1'b1;
        key_cnt     <= key_cnt + KEY_CNT_W'(1);
      end else if (hs) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign bus.key_ready = key_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_key   = out_key_q;
  assign bus.out_index = out_index_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_aes192_key_schedule_seq.sv
// Directed bench for aes192_key_schedule_seq: FIPS-197 A.2 vectors, stalls, reset abort, small builds.
module tb_aes192_key_schedule_seq;
  localparam logic [191:0] KEY_A2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [31:0] A2W [52] = '{
    32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5, 32'h62f8ead2, 32'h522c6b7b,
    32'hfe0c91f7, 32'h2402f5a5, 32'hec12068e, 32'h6c827f6b, 32'h0e7a95b9, 32'h5c56fec2,
    32'h4db7b4bd, 32'h69b54118, 32'h85a74796, 32'he92538fd, 32'he75fad44, 32'hbb095386,
    32'h485af057, 32'h21efb14f, 32'ha448f6d9, 32'h4d6dce24, 32'haa326360, 32'h113b30e6,
    32'ha25e7ed5, 32'h83b1cf9a, 32'h27f93943, 32'h6a94f767, 32'hc0a69407, 32'hd19da4e1,
    32'hec1786eb, 32'h6fa64971, 32'h485f7032, 32'h22cb8755, 32'he26d1352, 32'h33f0b7b3,
    32'h40beeb28, 32'h2f18a259, 32'h6747d26b, 32'h458c553e, 32'ha7e1466c, 32'h9411f1df,
    32'h821f750a, 32'had07d753, 32'hca400538, 32'h8fcc5006, 32'h282d166a, 32'hbc3ce7b5,
    32'he98ba06f, 32'h448c773c, 32'h8ecc7204, 32'h01002202
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  aes192_key_schedule_seq_if ifc ();
  aes192_key_schedule_seq_if ifc1 ();
  aes192_key_schedule_seq_if ifc4 ();

  aes192_key_schedule_seq #(.NUM_ROUND_KEYS(13)) dut  (.clk(clk), .rst(rst), .bus(ifc.slave));
  aes192_key_schedule_seq #(.NUM_ROUND_KEYS(1))  dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));
  aes192_key_schedule_seq #(.NUM_ROUND_KEYS(4))  dut4 (.clk(clk), .rst(rst), .bus(ifc4.slave));

  logic [127:0] got_key  [16];
  logic [3:0]   got_idx  [16];
  logic         got_last [16];
  int           got_cyc  [16];
  int           got_n;
  int           unstable;

  function automatic logic [127:0] rk_a2(input int k);
    return {A2W[4*k], A2W[4*k+1], A2W[4*k+2], A2W[4*k+3]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [191:0] k);
    ifc.key_in    = k;
    ifc.key_valid = 1'b1;
    for (int i = 0; i < 10 && !ifc.key_ready; i++) tick();
    tick();
    ifc.key_valid = 1'b0;
  endtask

  // Records handshakes on the main instance; out_ready is low low_pct percent of cycles.
  task automatic collect(input int n, input int low_pct, input int budget);
    logic         prev_stall;
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;
    int           cyc;
    got_n = 0;
    unstable = 0;
    prev_stall = 1'b0;
    prev_key = '0;
    prev_idx = '0;
    cyc = 0;
    while (got_n < n && cyc < budget) begin
      ifc.out_ready = ($urandom_range(0, 99) >= low_pct);
      if (prev_stall && (!ifc.out_valid || ifc.out_key !== prev_key || ifc.out_index !== prev_idx))
        unstable++;
      if (ifc.out_valid && ifc.out_ready && got_n < 16) begin
        got_key[got_n]  = ifc.out_key;
        got_idx[got_n]  = ifc.out_index;
        got_last[got_n] = ifc.out_last;
        got_cyc[got_n]  = cyc;
        got_n++;
      end
      prev_stall = ifc.out_valid && !ifc.out_ready;
      prev_key   = ifc.out_key;
      prev_idx   = ifc.out_index;
      tick();
      cyc++;
    end
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (ifc.key_ready !== 1'b1 || ifc.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl key_ready=%b busy=%b expected 1/0", ifc.key_ready, ifc.busy);
    end
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.out_last !== 1'b0 || ifc.out_key !== 128'h0 || ifc.out_index !== 4'd0) begin
      failures++;
      $display("FAIL reset_out valid=%b last=%b key=%h idx=%0d expected all zero",
               ifc.out_valid, ifc.out_last, ifc.out_key, ifc.out_index);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic check_a2_sequence(input string name);
    checks++;
    if (got_n !== 13) begin
      failures++;
      $display("FAIL %s_count got=%0d expected 13", name, got_n);
    end
    for (int k = 0; k < got_n && k < 13; k++) begin
      checks++;
      if (got_key[k] !== rk_a2(k) || got_idx[k] !== 4'(k) || got_last[k] !== (k == 12)) begin
        failures++;
        $display("FAIL %s_rk%0d got=%h idx=%0d last=%b expected=%h idx=%0d last=%b",
                 name, k, got_key[k], got_idx[k], got_last[k], rk_a2(k), k, (k == 12));
      end
    end
  endtask

  task automatic test_fips_ready;
    int last_cyc;
    int max_gap;
    send_key(KEY_A2);
    collect(13, 0, 100);
    check_a2_sequence("fips");
    last_cyc = (got_n == 13) ? got_cyc[12] : 9999;
    checks++;
    if (last_cyc > 60) begin
      failures++;
      $display("FAIL fips_latency rk12_cycle=%0d expected <=60", last_cyc);
    end
    max_gap = 0;
    for (int k = 1; k < got_n; k++)
      if (got_cyc[k] - got_cyc[k-1] > max_gap) max_gap = got_cyc[k] - got_cyc[k-1];
    checks++;
    if (max_gap > 5) begin
      failures++;
      $display("FAIL fips_gap max_interval=%0d expected <=5", max_gap);
    end
    checks++;
    if (ifc.busy !== 1'b0 || ifc.key_ready !== 1'b1) begin
      failures++;
      $display("FAIL fips_idle busy=%b key_ready=%b expected 0/1", ifc.busy, ifc.key_ready);
    end
  endtask

  task automatic test_stall_random;
    send_key(KEY_A2);
    collect(13, 30, 400);
    check_a2_sequence("stall");
    checks++;
    if (unstable !== 0) begin
      failures++;
      $display("FAIL stall_stable changes_while_stalled=%0d expected 0", unstable);
    end
  endtask

  task automatic test_reset_mid;
    send_key(KEY_A2);
    collect(13, 0, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.key_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_state valid=%b busy=%b key_ready=%b expected 0/0/1",
               ifc.out_valid, ifc.busy, ifc.key_ready);
    end
    send_key(192'h0);
    collect(13, 0, 100);
    checks++;
    if (got_n !== 13 || got_last[12] !== 1'b1 || got_idx[12] !== 4'd12) begin
      failures++;
      $display("FAIL rstmid_complete count=%0d last=%b idx=%0d expected 13/1/12",
               got_n, got_last[12], got_idx[12]);
    end
    checks++;
    if (got_key[0] !== 128'h0) begin
      failures++;
      $display("FAIL rstmid_rk0 got=%h expected 0", got_key[0]);
    end
    checks++;
    if (got_key[1] !== 128'h00000000000000006263636362636363) begin
      failures++;
      $display("FAIL rstmid_rk1 got=%h expected 00000000000000006263636362636363", got_key[1]);
    end
  endtask

  task automatic test_key_valid_held;
    int hs_cnt;
    int kr_high;
    int cyc;
    ifc.key_in    = KEY_A2;
    ifc.key_valid = 1'b1;
    for (int i = 0; i < 10 && !ifc.key_ready; i++) tick();
    tick();
    ifc.out_ready = 1'b1;
    hs_cnt = 0;
    kr_high = 0;
    cyc = 0;
    while (hs_cnt < 13 && cyc < 100) begin
      if (ifc.key_ready) kr_high++;
      if (ifc.out_valid && ifc.out_ready) hs_cnt++;
      tick();
      cyc++;
    end
    ifc.out_ready = 1'b0;
    checks++;
    if (hs_cnt !== 13 || kr_high !== 0) begin
      failures++;
      $display("FAIL held_expansion handshakes=%0d key_ready_cycles=%0d expected 13/0", hs_cnt, kr_high);
    end
    checks++;
    if (ifc.key_ready !== 1'b1 || ifc.busy !== 1'b0) begin
      failures++;
      $display("FAIL held_idle key_ready=%b busy=%b expected 1/0", ifc.key_ready, ifc.busy);
    end
    tick();
    ifc.key_valid = 1'b0;
    checks++;
    if (ifc.busy !== 1'b1 || ifc.out_valid !== 1'b1 || ifc.out_index !== 4'd0 || ifc.out_key !== rk_a2(0)) begin
      failures++;
      $display("FAIL held_second busy=%b valid=%b idx=%0d key=%h expected 1/1/0/%h",
               ifc.busy, ifc.out_valid, ifc.out_index, ifc.out_key, rk_a2(0));
    end
    collect(13, 0, 100);
    check_a2_sequence("held2");
  endtask

  task automatic test_long_stall;
    int bad;
    send_key(KEY_A2);
    ifc.out_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (!ifc.out_valid || ifc.out_index !== 4'd0 || ifc.out_key !== rk_a2(0) || !ifc.busy) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL long_hold bad_cycles=%0d expected 0", bad);
    end
    collect(13, 0, 200);
    check_a2_sequence("long");
    checks++;
    if (got_n < 2 || got_cyc[1] !== 1) begin
      failures++;
      $display("FAIL long_buffered rk1_cycle=%0d expected 1", (got_n < 2) ? -1 : got_cyc[1]);
    end
  endtask

  task automatic test_small_builds;
    int n4;
    int lasts;
    int cyc;
    logic [3:0]   last_idx;
    logic [127:0] last_key;
    ifc1.key_in    = KEY_A2;
    ifc1.key_valid = 1'b1;
    tick();
    ifc1.key_valid = 1'b0;
    checks++;
    if (ifc1.out_valid !== 1'b1 || ifc1.out_last !== 1'b1 || ifc1.out_index !== 4'd0 || ifc1.out_key !== rk_a2(0)) begin
      failures++;
      $display("FAIL n1_rk0 valid=%b last=%b idx=%0d key=%h expected 1/1/0/%h",
               ifc1.out_valid, ifc1.out_last, ifc1.out_index, ifc1.out_key, rk_a2(0));
    end
    ifc1.out_ready = 1'b1;
    tick();
    ifc1.out_ready = 1'b0;
    checks++;
    if (ifc1.out_valid !== 1'b0 || ifc1.busy !== 1'b0 || ifc1.key_ready !== 1'b1) begin
      failures++;
      $display("FAIL n1_idle valid=%b busy=%b key_ready=%b expected 0/0/1",
               ifc1.out_valid, ifc1.busy, ifc1.key_ready);
    end

    ifc4.key_in    = KEY_A2;
    ifc4.key_valid = 1'b1;
    tick();
    ifc4.key_valid = 1'b0;
    ifc4.out_ready = 1'b1;
    n4 = 0;
    lasts = 0;
    cyc = 0;
    last_idx = 4'hf;
    last_key = '0;
    while (lasts == 0 && cyc < 60) begin
      if (ifc4.out_valid && ifc4.out_ready) begin
        n4++;
        if (ifc4.out_last) begin
          lasts++;
          last_idx = ifc4.out_index;
          last_key = ifc4.out_key;
        end
      end
      tick();
      cyc++;
    end
    ifc4.out_ready = 1'b0;
    checks++;
    if (n4 !== 4 || last_idx !== 4'd3 || last_key !== rk_a2(3)) begin
      failures++;
      $display("FAIL n4_last count=%0d idx=%0d key=%h expected 4/3/%h", n4, last_idx, last_key, rk_a2(3));
    end
    checks++;
    if (ifc4.busy !== 1'b0 || ifc4.key_ready !== 1'b1 || ifc4.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL n4_idle busy=%b key_ready=%b valid=%b expected 0/1/0",
               ifc4.busy, ifc4.key_ready, ifc4.out_valid);
    end
  endtask

  initial begin
    ifc.key_in = '0;  ifc.key_valid = 1'b0;  ifc.out_ready = 1'b0;
    ifc1.key_in = '0; ifc1.key_valid = 1'b0; ifc1.out_ready = 1'b0;
    ifc4.key_in = '0; ifc4.key_valid = 1'b0; ifc4.out_ready = 1'b0;
    test_reset();
    test_fips_ready();
    test_stall_random();
    test_reset_mid();
    test_key_valid_held();
    test_long_stall();
    test_small_builds();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
